// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: sequences SPI slave FIFO bytes into register-bus writes and reads.
// Optional macro SPI_REG_AUTOINC_EN: address advances after every reg_wr and TX push.
module spi_reg_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             CS_n,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_empty,
    output logic             rx_read_en,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_write_en,
    input  logic             tx_full,
    output logic [WIDTH-2:0] reg_addr,
    output logic [WIDTH-1:0] reg_wdata,
    output logic             reg_wr,
    output logic             reg_rd,
    input  logic [WIDTH-1:0] reg_rdata,
    input  logic             reg_rvalid,
    output logic             busy
);
    localparam int unsigned AW = WIDTH - 1;

    localparam logic [2:0] CMD_WAIT  = 3'd0;
    localparam logic [2:0] CMD_LOAD  = 3'd1;
    localparam logic [2:0] DATA_WAIT = 3'd2;
    localparam logic [2:0] DATA_LOAD = 3'd3;
    localparam logic [2:0] WR_DONE   = 3'd4;
    localparam logic [2:0] RD_REQ    = 3'd5;
    localparam logic [2:0] RD_WAIT   = 3'd6;
    localparam logic [2:0] RD_PUSH   = 3'd7;

    logic [2:0]       r_state, w_state_nxt;
    logic             r_rw, w_rw_nxt;
    logic [AW-1:0]    r_addr, w_addr_nxt, w_addr_inc;
    logic [WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [WIDTH-1:0] r_tx_data, w_tx_data_nxt;
    logic             r_rx_read_en, w_rx_read_en_nxt;
    logic             r_tx_write_en, w_tx_write_en_nxt;
    logic             r_reg_wr, w_reg_wr_nxt;
    logic             r_reg_rd, w_reg_rd_nxt;
    logic             r_end_pend, w_end_pend_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_cs_meta, r_cs_sync, r_cs_prev;
    logic             w_cs_rise;

`ifdef SPI_REG_AUTOINC_EN
    assign w_addr_inc = r_addr + AW'(1);
`else
    assign w_addr_inc = r_addr;
`endif

    // CS_n synchroniser and rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_meta <= 1'b1;
            r_cs_sync <= 1'b1;
            r_cs_prev <= 1'b1;
        end else begin
            r_cs_meta <= CS_n;
            r_cs_sync <= r_cs_meta;
            r_cs_prev <= r_cs_sync;
        end
    end

    assign w_cs_rise = r_cs_sync & ~r_cs_prev;

    // A pop strobe holds the wait state one extra cycle so the LOAD state sees valid rx_data
    always_comb begin
        w_state_nxt       = r_state;
        w_rw_nxt          = r_rw;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_tx_data_nxt     = r_tx_data;
        w_rx_read_en_nxt  = 1'b0;
        w_tx_write_en_nxt = 1'b0;
        w_reg_wr_nxt      = 1'b0;
        w_reg_rd_nxt      = 1'b0;
        w_end_pend_nxt    = r_end_pend | w_cs_rise;
        case (r_state)
            CMD_WAIT: begin
                if (r_rx_read_en) w_state_nxt = CMD_LOAD;
                else if (!rx_empty) w_rx_read_en_nxt = 1'b1;
                else w_end_pend_nxt = 1'b0;
            end
            CMD_LOAD: begin
                w_rw_nxt    = rx_data[WIDTH-1];
                w_addr_nxt  = rx_data[WIDTH-2:0];
                w_state_nxt = rx_data[WIDTH-1] ? RD_REQ : DATA_WAIT;
            end
            DATA_WAIT: begin
                if (r_rx_read_en) begin
                    w_state_nxt = DATA_LOAD;
                end else if (!rx_empty) begin
                    w_rx_read_en_nxt = 1'b1;
                end else if (r_end_pend) begin
                    w_end_pend_nxt = 1'b0;
                    w_state_nxt    = CMD_WAIT;
                end
            end
            DATA_LOAD: begin
                if (r_rw) begin
                    w_state_nxt = RD_REQ;
                end else begin
                    w_wdata_nxt  = rx_data;
                    w_reg_wr_nxt = 1'b1;
                    w_state_nxt  = WR_DONE;
                end
            end
            WR_DONE: begin
                w_addr_nxt  = w_addr_inc;
                w_state_nxt = DATA_WAIT;
            end
            RD_REQ: begin
                w_reg_rd_nxt = 1'b1;
                w_state_nxt  = RD_WAIT;
            end
            RD_WAIT: begin
                if (reg_rvalid) begin
                    w_tx_data_nxt = reg_rdata;
                    w_state_nxt   = RD_PUSH;
                end
            end
            RD_PUSH: begin
                if (!tx_full) begin
                    w_tx_write_en_nxt = 1'b1;
                    w_addr_nxt        = w_addr_inc;
                    w_state_nxt       = DATA_WAIT;
                end
            end
            default: w_state_nxt = CMD_WAIT;
        endcase
        w_busy_nxt = (w_state_nxt != CMD_WAIT) || w_end_pend_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= CMD_WAIT;
            r_rw          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_tx_data     <= '0;
            r_rx_read_en  <= 1'b0;
            r_tx_write_en <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_reg_rd      <= 1'b0;
            r_end_pend    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rw          <= w_rw_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_rx_read_en  <= w_rx_read_en_nxt;
            r_tx_write_en <= w_tx_write_en_nxt;
            r_reg_wr      <= w_reg_wr_nxt;
            r_reg_rd      <= w_reg_rd_nxt;
            r_end_pend    <= w_end_pend_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign rx_read_en  = r_rx_read_en;
    assign tx_write_en = r_tx_write_en;
    assign tx_data     = r_tx_data;
    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;
    assign reg_wr      = r_reg_wr;
    assign reg_rd      = r_reg_rd;
    assign busy        = r_busy;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed bench with RX/TX FIFO and register-file models around spi_reg_ctrl.
// Expected values follow the SPI_REG_AUTOINC_EN setting of the build.
module tb_spi_reg_ctrl;
`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       CS_n;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_read_en;
    logic [7:0] tx_data;
    logic       tx_write_en;
    logic       tx_full;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       reg_rvalid;
    logic       busy;

    spi_reg_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .CS_n(CS_n),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_read_en(rx_read_en),
        .tx_data(tx_data), .tx_write_en(tx_write_en), .tx_full(tx_full),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;

    logic [7:0] rx_q [$];
    logic [7:0] regs [128];
    int         rd_delay;
    int         rd_cnt;
    logic [6:0] rd_addr_m;

    logic [7:0] wr_addr_log [$];
    logic [7:0] wr_data_log [$];
    logic [7:0] rd_addr_log [$];
    logic [7:0] tx_log [$];
    logic       p_rx, p_tx, p_wr, p_rd;

    // RX FIFO: pop on a sampled read strobe, data valid the following cycle
    always @(posedge clk) begin
        if (rx_read_en && rx_q.size() > 0) begin
            rx_data <= rx_q.pop_front();
            if (rx_q.size() == 0) rx_empty <= 1'b1;
        end
    end

    // Register file with configurable read latency
    always @(posedge clk) begin
        reg_rvalid <= 1'b0;
        if (reg_rd) begin
            rd_cnt    <= rd_delay;
            rd_addr_m <= reg_addr;
        end else if (rd_cnt != 0) begin
            rd_cnt <= rd_cnt - 1;
            if (rd_cnt == 1) begin
                reg_rvalid <= 1'b1;
                reg_rdata  <= regs[rd_addr_m];
            end
        end
        if (reg_wr) regs[reg_addr] <= reg_wdata;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr) begin
                wr_addr_log.push_back({1'b0, reg_addr});
                wr_data_log.push_back(reg_wdata);
            end
            if (reg_rd) rd_addr_log.push_back({1'b0, reg_addr});
            if (tx_write_en) tx_log.push_back(tx_data);
            if ((rx_read_en && p_rx) || (tx_write_en && p_tx) || (reg_wr && p_wr) ||
                (reg_rd && p_rd) || (reg_wr && reg_rd)) viol++;
        end
        p_rx = rx_read_en;
        p_tx = tx_write_en;
        p_wr = reg_wr;
        p_rd = reg_rd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_rx(input logic [7:0] v);
        @(negedge clk);
        rx_q.push_back(v);
        rx_empty = 1'b0;
    endtask

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
        tx_log.delete();
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int n, input int gap);
        logic [7:0] b [3];
        b[0] = b0;
        b[1] = b1;
        b[2] = b2;
        @(negedge clk);
        CS_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_rx(b[i]);
            repeat (gap) @(negedge clk);
        end
        CS_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((busy || !rx_empty) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k < 300), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; CS_n = 1'b1; tx_full = 1'b0;
        rx_empty = 1'b1; rx_data = 8'h00;
        reg_rvalid = 1'b0; reg_rdata = 8'h00;
        rd_delay = 1; rd_cnt = 0; rd_addr_m = 7'h00;
        p_rx = 1'b0; p_tx = 1'b0; p_wr = 1'b0; p_rd = 1'b0;
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        regs[3] = 8'h11; regs[4] = 8'h22; regs[5] = 8'h33;

        #1;
        check("rst_strobes_busy", 32'({rx_read_en, tx_write_en, reg_wr, reg_rd, busy}), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_data", 32'({reg_wdata, tx_data}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read burst and back-to-back frames
        clear_logs();
        send_frame(8'h83, 8'h00, 8'h00, 3, 10);
        wait_idle("rd_idle");
        check("rd_push_cnt", 32'(tx_log.size()), 32'd3);
        check("rd_data0", 32'(tx_log[0]), 32'h11);
        check("rd_data1", 32'(tx_log[1]), AUTOINC ? 32'h22 : 32'h11);
        check("rd_data2", 32'(tx_log[2]), AUTOINC ? 32'h33 : 32'h11);
        check("rd_addr0", 32'(rd_addr_log[0]), 32'h03);
        check("rd_addr2", 32'(rd_addr_log[2]), AUTOINC ? 32'h05 : 32'h03);

        // Write burst
        clear_logs();
        send_frame(8'h05, 8'hAA, 8'hBB, 3, 10);
        wait_idle("wr_idle");
        check("wr_cnt", 32'(wr_addr_log.size()), 32'd2);
        check("wr0", 32'({wr_addr_log[0], wr_data_log[0]}), 32'h05AA);
        check("wr1", 32'({wr_addr_log[1], wr_data_log[1]}), AUTOINC ? 32'h06BB : 32'h05BB);
        check("wr_no_tx", 32'(tx_log.size()), 32'd0);

        // Address wrap
        clear_logs();
        send_frame(8'h7F, 8'h01, 8'h02, 3, 10);
        wait_idle("wrap_idle");
        check("wrap0", 32'({wr_addr_log[0], wr_data_log[0]}), 32'h7F01);
        check("wrap1", 32'({wr_addr_log[1], wr_data_log[1]}), AUTOINC ? 32'h0002 : 32'h7F02);

        // TX backpressure held in RD_PUSH
        clear_logs();
        tx_full = 1'b1;
        @(negedge clk);
        CS_n = 1'b0;
        push_rx(8'h84);
        repeat (20) @(negedge clk);
        check("bp_no_push", 32'(tx_log.size()), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        tx_full = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_one_push", 32'(tx_log.size()), 32'd1);
        check("bp_data", 32'(tx_log[0]), 32'h22);
        CS_n = 1'b1;
        repeat (12) @(negedge clk);
        wait_idle("bp_idle");

        // Frame end with data still queued, then command-only frame
        clear_logs();
        send_frame(8'h20, 8'h5A, 8'hA5, 3, 0);
        wait_idle("fe_idle");
        check("fe_cnt", 32'(wr_addr_log.size()), 32'd2);
        check("fe0", 32'({wr_addr_log[0], wr_data_log[0]}), 32'h205A);
        check("fe1", 32'({wr_addr_log[1], wr_data_log[1]}), AUTOINC ? 32'h21A5 : 32'h20A5);
        clear_logs();
        send_frame(8'h10, 8'h00, 8'h00, 1, 4);
        wait_idle("co_idle");
        check("co_no_wr", 32'(wr_addr_log.size()), 32'd0);
        check("co_addr", 32'(reg_addr), 32'h10);
        send_frame(8'h30, 8'h77, 8'h00, 2, 10);
        wait_idle("nx_idle");
        check("nx_wr", 32'({wr_addr_log[0], wr_data_log[0]}), 32'h3077);

        // Async reset in RD_WAIT, late reg_rvalid ignored
        clear_logs();
        rd_delay = 30;
        @(negedge clk);
        CS_n = 1'b0;
        push_rx(8'h84);
        repeat (10) @(negedge clk);
        check("ar_rd_issued", 32'(rd_addr_log.size()), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_strobes_busy", 32'({rx_read_en, tx_write_en, reg_wr, reg_rd, busy}), 32'd0);
        check("ar_reg_addr", 32'(reg_addr), 32'd0);
        check("ar_data", 32'({reg_wdata, tx_data}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("ar_no_push", 32'(tx_log.size()), 32'd0);
        check("ar_idle", 32'(busy), 32'd0);
        CS_n = 1'b1;
        repeat (12) @(negedge clk);
        rd_delay = 1;
        clear_logs();
        send_frame(8'h01, 8'h99, 8'h00, 2, 10);
        wait_idle("ar_post_idle");
        check("ar_post_wr", 32'({wr_addr_log[0], wr_data_log[0]}), 32'h0199);

        check("strobe_rules", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
